// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor
//   Streaming error monitor for approximate ripple-carry adders. Each accepted
//   sample (in_a, in_b, in_approx) is compared against the exact sum and the
//   sum of absolute errors, the maximum absolute error and the count of
//   erroneous samples are accumulated over a programmed number of samples.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start, num_samples  run request (honoured in IDLE/DONE), sample count
//     in_valid, in_ready  sample stream handshake
//     in_a, in_b          operands (WIDTH bits)
//     in_approx           approximate sum under test (WIDTH+1 bits)
//     busy, done          RUN/FLUSH indicator, one-cycle completion pulse
//     sum_abs_err         saturating sum of |exact - approx| (ACC_W bits)
//     max_abs_err         largest |exact - approx| seen (WIDTH+1 bits)
//     err_count           saturating count of nonzero errors (CNT_W bits)
//
//   Build option ERR_MON_SELF_MODEL_EN: ignore in_approx and form the
//   approximate sum internally (APPROX_BITS LSBs use the approximate cell).
module approx_add_err_monitor #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  // Wide enough to hold either operand of the accumulate plus a carry.
  localparam int unsigned SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic             v1_q;
  logic [WIDTH:0]   err1_q;
  logic [ACC_W-1:0] sum_q;
  logic [WIDTH:0]   max_q;
  logic [CNT_W-1:0] errcnt_q;
  logic             done_q;

  logic             xfer;
  logic             clr;
  logic             enter_done;
  logic [WIDTH:0]   exact_w;
  logic [WIDTH:0]   approx_w;
  logic [WIDTH:0]   err_w;
  logic [SW-1:0]    sum_wide;

`ifdef ERR_MON_SELF_MODEL_EN
  // Approximate cell (X=a, Y=b, Z=carry-in): S = X~Y | Y~Z, Cout = Y | ~Z.
  function automatic logic [WIDTH:0] approx_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic           c;
    logic [WIDTH:0] s;
    c = 1'b0;
    s = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < APPROX_BITS) begin
        s[i] = (a[i] & ~b[i]) | (b[i] & ~c);
        c    = b[i] | ~c;
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    s[WIDTH] = c;
    return s;
  endfunction

  logic [WIDTH:0] unused_approx;
  assign unused_approx = in_approx;
  assign approx_w      = approx_sum(in_a, in_b);
`else
  localparam int unsigned unused_approx_bits = APPROX_BITS;
  assign approx_w = in_approx;
`endif

  assign exact_w = {1'b0, in_a} + {1'b0, in_b};
  assign err_w   = (exact_w >= approx_w) ? (exact_w - approx_w) : (approx_w - exact_w);

  assign in_ready    = (state_q == S_RUN);
  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done        = done_q;
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign err_count   = errcnt_q;

  assign xfer     = in_valid && (state_q == S_RUN);
  assign sum_wide = SW'(sum_q) + SW'(err1_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    clr        = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr        = 1'b1;
          count_d    = num_samples;
          accepted_d = '0;
          if (num_samples == '0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          accepted_d = accepted_q + CNT_W'(1);
          if (accepted_d == count_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Stage 1 can only hold the final sample here, and it commits to the
        // stats on this same edge, so the pipeline is empty after one cycle.
        state_d    = S_DONE;
        enter_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      accepted_q <= '0;
      v1_q       <= 1'b0;
      err1_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      errcnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      done_q     <= enter_done;
      // Stage 1: only the error magnitude is consumed downstream.
      v1_q       <= xfer;
      if (xfer) err1_q <= err_w;
      // Stage 2: stats update.
      if (clr) begin
        sum_q    <= '0;
        max_q    <= '0;
        errcnt_q <= '0;
      end else if (v1_q) begin
        if (sum_wide > SW'({ACC_W{1'b1}})) sum_q <= '1;
        else                               sum_q <= sum_wide[ACC_W-1:0];
        if (err1_q > max_q) max_q <= err1_q;
        if ((err1_q != '0) && (errcnt_q != '1)) errcnt_q <= errcnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
`timescale 1ns/1ps
module tb_approx_add_err_monitor;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] num_samples;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_approx;
  logic        in_ready, busy, done;
  logic [31:0] sum_abs_err;
  logic [8:0]  max_abs_err;
  logic [15:0] err_count;
  logic        sat_in_ready, sat_busy, sat_done;
  logic [3:0]  sat_sum;
  logic [8:0]  sat_max;
  logic [15:0] sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_add_err_monitor #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(16), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .err_count(err_count)
  );

  approx_add_err_monitor #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(16), .ACC_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(sat_busy), .done(sat_done),
    .sum_abs_err(sat_sum), .max_abs_err(sat_max), .err_count(sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  // Presents one sample and returns #1 after the edge that transfers it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
    int guard = 0;
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (!done && guard < 10) begin
      tick();
      guard++;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int xfers, last, dcyc, pulses;
    logic ready_after;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    in_a = '0; in_b = '0; in_approx = '0;
    tick(); tick();
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_abs_err, 0);
    check("rst_max", max_abs_err, 0);
    check("rst_cnt", err_count, 0);
    rst = 1'b0;
    tick();

    // Zero-count run completes immediately.
    do_start(16'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_ready", in_ready, 0);
    check("zero_sum", sum_abs_err, 0);
    tick();
    check("zero_done_pulse", done, 0);
    check("zero_ready2", in_ready, 0);

    // Main function.
`ifdef ERR_MON_SELF_MODEL_EN
    do_start(16'd4);
    check("main_busy", busy, 1);
    check("main_ready", in_ready, 1);
    send(8'd1, 8'd1, 9'd0);
    send(8'd3, 8'd3, 9'd0);
    send(8'd0, 8'd2, 9'd0);
    send(8'd255, 8'd255, 9'd0);
`else
    do_start(16'd3);
    check("main_busy", busy, 1);
    check("main_ready", in_ready, 1);
    send(8'd5, 8'd7, 9'd12);
    send(8'd5, 8'd7, 9'd10);
    send(8'd200, 8'd100, 9'd290);
`endif
    check("flush_ready", in_ready, 0);
    check("flush_busy", busy, 1);
    check("flush_done", done, 0);
    tick();
    check("main_done", done, 1);
    check("main_busy_end", busy, 0);
`ifdef ERR_MON_SELF_MODEL_EN
    check("main_sum", sum_abs_err, 5);
    check("main_max", max_abs_err, 2);
    check("main_cnt", err_count, 4);
`else
    check("main_sum", sum_abs_err, 12);
    check("main_max", max_abs_err, 10);
    check("main_cnt", err_count, 2);
`endif
    tick();
    check("main_done_pulse", done, 0);

    // Backpressure: valid toggles every cycle.
    do_start(16'd4);
    xfers = 0; last = -10; dcyc = -100; pulses = 0; ready_after = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_a = 8'd1; in_b = 8'd1; in_approx = 9'd0;
      in_valid = (c % 2 == 0);
      if (done) begin
        pulses++;
        dcyc = c;
      end
      if (xfers == 4 && c == last + 1) ready_after = in_ready;
      if (in_valid && in_ready) begin
        xfers++;
        last = c;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_xfers", xfers, 4);
    check("bp_ready_after", ready_after, 0);
    check("bp_done_delay", dcyc - last, 2);
    check("bp_done_pulses", pulses, 1);
`ifdef ERR_MON_SELF_MODEL_EN
    check("bp_sum", sum_abs_err, 4);
    check("bp_max", max_abs_err, 1);
`else
    check("bp_sum", sum_abs_err, 8);
    check("bp_max", max_abs_err, 2);
`endif
    check("bp_cnt", err_count, 4);

    // Saturation with a start ignored while busy.
    do_start(16'd3);
`ifdef ERR_MON_SELF_MODEL_EN
    send(8'd0, 8'd2, 9'd0);
`else
    send(8'd0, 8'd0, 9'd7);
`endif
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    check("busy_start_busy", busy, 1);
`ifdef ERR_MON_SELF_MODEL_EN
    send(8'd0, 8'd2, 9'd0);
    send(8'd0, 8'd2, 9'd0);
`else
    send(8'd0, 8'd0, 9'd7);
    send(8'd0, 8'd0, 9'd7);
`endif
    wait_done("sat_wait_done");
    check("sat_done", sat_done, 1);
    check("sat_busy", sat_busy, 0);
    check("sat_cnt", sat_cnt, 3);
`ifdef ERR_MON_SELF_MODEL_EN
    check("sat_sum", sat_sum, 6);
    check("sat_max", sat_max, 2);
    check("sat_main_sum", sum_abs_err, 6);
`else
    check("sat_sum", sat_sum, 15);
    check("sat_max", sat_max, 7);
    check("sat_main_sum", sum_abs_err, 21);
`endif
    check("sat_main_cnt", err_count, 3);

    // Re-arm from DONE clears the stats.
    do_start(16'd1);
    check("rearm_busy", busy, 1);
    check("rearm_ready", sat_in_ready, 1);
    check("rearm_sum", sum_abs_err, 0);
    check("rearm_max", max_abs_err, 0);
    check("rearm_cnt", err_count, 0);
    check("rearm_sat_sum", sat_sum, 0);
    send(8'd0, 8'd0, 9'd0);
    wait_done("rearm_wait_done");
    check("rearm_end_cnt", err_count, 0);

    // Reset in the middle of a run.
    do_start(16'd5);
    send(8'd1, 8'd1, 9'd0);
    send(8'd1, 8'd1, 9'd0);
    send(8'd1, 8'd1, 9'd0);
    check("mid_pre_cnt", err_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_ready", in_ready, 0);
    check("mid_done", done, 0);
    check("mid_sum", sum_abs_err, 0);
    check("mid_max", max_abs_err, 0);
    check("mid_cnt", err_count, 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || in_ready) pulses++;
      tick();
    end
    check("mid_quiet", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Streaming error monitor on the output side of the approximate ripple-carry adders.
- Accepts operand pairs and the approximate sum produced by an approximate adder.
- Computes the exact sum and accumulates these statistics over a programmed number of samples: sum of absolute error, maximum absolute error, and count of erroneous results.
- Used in the pwr-mae characterisation flow, with a valid/ready input stream and a start/done control handshake.

Parameters:
- WIDTH, 8: operand width; sums are WIDTH+1 bits.
- APPROX_BITS, 2: number of LSB positions using the approximate cell (used only by the self-model option); 0..WIDTH.
- CNT_W, 16: width of num_samples and err_count.
- ACC_W, 32: width of sum_abs_err accumulator.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a measurement run; honoured only in IDLE or DONE.
- num_samples, input, CNT_W: sample count, sampled on accepted start.
- in_valid, input, 1: sample present.
- in_ready, output, 1: monitor accepts a sample this cycle.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_approx, input, WIDTH+1: approximate sum under test.
- busy, output, 1: high in RUN or FLUSH.
- done, output, 1: one-cycle pulse when results become valid.
- sum_abs_err, output, ACC_W: accumulated absolute error.
- max_abs_err, output, WIDTH+1: largest absolute error seen.
- err_count, output, CNT_W: number of samples with nonzero error.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=0, busy=0, done=0; sum_abs_err, max_abs_err and err_count all 0. Reset mid-run aborts the run with no done pulse.
- States and transitions:
  - IDLE: on start, clear all stats and latch num_samples. If latched count=0, go to DONE and pulse done with zero results; else go to RUN.
  - RUN: in_ready=1. A sample transfers when in_valid&in_ready. After the transfer that makes accepted==count, in_ready drops the next cycle and state goes to FLUSH.
  - FLUSH: in_ready=0; wait until the pipeline is empty, then go to DONE and pulse done for one cycle.
  - DONE: results held stable. start re-arms as from IDLE; otherwise stay.
- start while busy is ignored.
- Pipeline, latency 2 from acceptance to stats update:
  - Stage 1 registers exact=in_a+in_b (WIDTH+1 bits, zero-extended), the approximate value, and |exact-approx| (unsigned magnitude, WIDTH+1 bits).
  - Stage 2 performs the updates:
    - sum_abs_err += err, saturating at all-ones;
    - max_abs_err = max(max_abs_err, err);
    - err_count += (err!=0), saturating.
- done asserts exactly 2 cycles after the last accepted sample if no stall (one FLUSH cycle plus one DONE entry).
- Stats outputs are visible live during RUN; they are final only at done.
- in_valid without in_ready is not consumed; inputs are held by the source per valid/ready rules.

Optional Feature:
- Macro: ERR_MON_SELF_MODEL_EN.
- Defined:
  - in_approx is ignored.
  - The approximate sum is computed internally as a ripple chain with carry-in 0.
  - Bit positions below APPROX_BITS use the approximate cell, inputs (X,Y,Z):
    - S=1 only for 010, 100, 101, 110;
    - Cout=0 only for 001 and 101.
  - Remaining positions use exact full adders; the final carry becomes bit WIDTH.
- Not defined: in_approx is used directly; no adder logic is instantiated beyond the exact sum.

Test Plan:
- Reset: assert rst mid-RUN after 3 samples -> next cycle busy=0, in_ready=0, all stats 0, no done pulse.
- Zero count: start with num_samples=0 -> DONE, done pulse, all stats 0, in_ready never high.
- External approx (macro off), count=3, samples (a,b,approx) = (5,7,12), (5,7,10), (200,100,290) -> done; sum_abs_err=12, max_abs_err=10, err_count=2.
- Self-model (macro on, WIDTH=8, APPROX_BITS=2), count=4, samples (1,1), (3,3), (0,2), (255,255):
  - internal approx = 1, 5, 4, 509;
  - expected sum_abs_err=5, max_abs_err=2, err_count=4.
- Backpressure/stall: count=4, in_valid toggled 1,0,1,0,...:
  - exactly 4 transfers;
  - in_ready low from the cycle after the 4th transfer;
  - done pulses 2 cycles after the 4th transfer.
- Saturation: ACC_W=4, count=3, each error=7 -> sum_abs_err=15 (saturated), max_abs_err=7; start while busy ignored; start in DONE re-arms with cleared stats.
